// File: rtl/bcd_serial_collector.sv
// Serial BCD collector: assembles LSB-first 4-bit digits into NUM_DIGITS-digit words behind a one-word skid buffer.
// Optional binary conversion of each word is enabled by defining BIN_OUT_EN (adds the word_bin port).
module bcd_serial_collector #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Z_in,
    input  logic                      bit_en,
    input  logic                      clr,
    output logic [3:0]                digit,
    output logic                      digit_valid,
    output logic                      digit_err,
    output logic [4*NUM_DIGITS-1:0]   word,
    output logic                      word_err,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      overrun,
    output logic                      fsm_state
`ifdef BIN_OUT_EN
    ,
    output logic [BIN_W-1:0]          word_bin
`endif
);

    localparam int W   = 4 * NUM_DIGITS;
    localparam int DCW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [2:0]       sh;
    logic [1:0]       bit_cnt;
    logic [DCW-1:0]   dig_cnt;
    logic [W-1:0]     asm_r;
    logic             asm_err;

    logic [3:0]       new_digit;
    logic             new_err;
    logic             dig_done;
    logic             word_done;
    logic [W-1:0]     asm_next;
    logic             asm_err_next;

    assign new_digit    = {Z_in, sh};
    assign new_err      = (new_digit > 4'd9);
    assign dig_done     = bit_en && !clr && (bit_cnt == 2'd3);
    assign word_done    = dig_done && (dig_cnt == DCW'(NUM_DIGITS - 1));
    assign asm_next     = (asm_r << 4) | W'(new_digit);
    assign asm_err_next = asm_err | new_err;
    assign fsm_state    = (state == FULL);

`ifdef BIN_OUT_EN
    logic [BIN_W-1:0] acc;
    logic [BIN_W-1:0] acc_base;
    logic [BIN_W-1:0] acc_next;

    // The first digit of a word starts from zero so no explicit word-start clear is needed.
    assign acc_base = (dig_cnt == '0) ? '0 : acc;
    assign acc_next = acc_base * BIN_W'(10) + BIN_W'(new_digit);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (dig_done) begin
            acc <= word_done ? '0 : acc_next;
        end
    end
`endif

    // Bit and digit assembly.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sh          <= '0;
            bit_cnt     <= '0;
            dig_cnt     <= '0;
            asm_r       <= '0;
            asm_err     <= 1'b0;
            digit       <= '0;
            digit_valid <= 1'b0;
            digit_err   <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            digit_err   <= 1'b0;
            if (clr) begin
                bit_cnt <= '0;
                dig_cnt <= '0;
                asm_r   <= '0;
                asm_err <= 1'b0;
            end else if (bit_en) begin
                sh      <= {Z_in, sh[2:1]};
                bit_cnt <= bit_cnt + 2'd1;
                if (bit_cnt == 2'd3) begin
                    digit       <= new_digit;
                    digit_valid <= 1'b1;
                    digit_err   <= new_err;
                    if (word_done) begin
                        dig_cnt <= '0;
                        asm_r   <= '0;
                        asm_err <= 1'b0;
                    end else begin
                        dig_cnt <= dig_cnt + DCW'(1);
                        asm_r   <= asm_next;
                        asm_err <= asm_err_next;
                    end
                end
            end
        end
    end

    // Handshake: a word transfers on a posedge where word_valid and word_ready are both 1;
    // while word_valid=1 and word_ready=0 the word, word_err and word_bin hold unchanged.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= EMPTY;
            word       <= '0;
            word_err   <= 1'b0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef BIN_OUT_EN
            word_bin   <= '0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (word_done) begin
                        word       <= asm_next;
                        word_err   <= asm_err_next;
`ifdef BIN_OUT_EN
                        word_bin   <= acc_next;
`endif
                        word_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (word_ready) begin
                        if (word_done) begin
                            word     <= asm_next;
                            word_err <= asm_err_next;
`ifdef BIN_OUT_EN
                            word_bin <= acc_next;
`endif
                        end else begin
                            word_valid <= 1'b0;
                            state      <= EMPTY;
                        end
                    end else if (word_done) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Self-checking bench for bcd_serial_collector: serial digit driver, word/digit scoreboards, per-scenario tasks.
module tb_bcd_serial_collector;

  localparam int N     = 4;
  localparam int W     = 4 * N;
  localparam int BIN_W = 14;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Z_in = 1'b0;
  logic bit_en = 1'b0;
  logic clr = 1'b0;
  logic word_ready = 1'b0;
  logic [3:0] digit;
  logic digit_valid;
  logic digit_err;
  logic [W-1:0] word;
  logic word_err;
  logic word_valid;
  logic overrun;
  logic fsm_state;
`ifdef BIN_OUT_EN
  logic [BIN_W-1:0] word_bin;
`endif

  int pass_cnt = 0;
  int chk_cnt = 0;
  int dig_seen = 0;
  int wv_cycles = 0;

  logic [W-1:0] exp_q[$];
  logic exp_err_q[$];
  logic [BIN_W-1:0] exp_bin_q[$];
  logic [4:0] dig_q[$];

  bcd_serial_collector #(.NUM_DIGITS(N), .BIN_W(BIN_W)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Z_in(Z_in),
    .bit_en(bit_en),
    .clr(clr),
    .digit(digit),
    .digit_valid(digit_valid),
    .digit_err(digit_err),
    .word(word),
    .word_err(word_err),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .overrun(overrun),
    .fsm_state(fsm_state)
`ifdef BIN_OUT_EN
    ,
    .word_bin(word_bin)
`endif
  );

  always #5 Clk = ~Clk;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    logic [4:0] e;
    logic ok;
    if (Rst) begin
      if (digit_valid) begin
        dig_seen++;
        chk_cnt++;
        if (dig_q.size() == 0) begin
          $display("FAIL digit_unexpected got=%h err=%b", digit, digit_err);
        end else begin
          e = dig_q.pop_front();
          if ({digit_err, digit} !== e)
            $display("FAIL digit got err=%b d=%h exp err=%b d=%h", digit_err, digit, e[4], e[3:0]);
          else
            pass_cnt++;
        end
      end
      if (word_valid) begin
        wv_cycles++;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL word_unexpected got=%h err=%b", word, word_err);
        end else begin
          ok = (word === exp_q[0]) && (word_err === exp_err_q[0]);
`ifdef BIN_OUT_EN
          if (!exp_err_q[0] && word_bin !== exp_bin_q[0]) ok = 1'b0;
          if (!ok) $display("FAIL word got=%h err=%b bin=%0d exp=%h err=%b bin=%0d",
                            word, word_err, word_bin, exp_q[0], exp_err_q[0], exp_bin_q[0]);
`else
          if (!ok) $display("FAIL word got=%h err=%b exp=%h err=%b", word, word_err, exp_q[0], exp_err_q[0]);
`endif
          if (ok) pass_cnt++;
          if (word_ready) begin
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            void'(exp_bin_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    Z_in = b;
    bit_en = 1'b1;
    @(posedge Clk);
    #1;
    bit_en = 1'b0;
    Z_in = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d, input int gap);
    dig_q.push_back({(d > 4'd9), d});
    for (int i = 0; i < 4; i++) begin
      send_bit(d[i]);
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = N - 1; i >= 0; i--) send_digit(w[4*i +: 4], gap);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic [BIN_W-1:0] acc;
    logic err;
    acc = '0;
    err = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      acc = acc * 14'd10 + {10'b0, w[4*i +: 4]};
      if (w[4*i +: 4] > 4'd9) err = 1'b1;
    end
    exp_q.push_back(w);
    exp_err_q.push_back(err);
    exp_bin_q.push_back(acc);
  endtask

  task automatic flush_expect();
    exp_q.delete();
    exp_err_q.delete();
    exp_bin_q.delete();
    dig_q.delete();
  endtask

  task automatic test_reset();
    logic [W+6:0] outs;
    tick(2);
    outs = {digit, digit_valid, digit_err, word, word_err, word_valid, overrun};
    chk_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs got=%h exp=0", outs);
    else pass_cnt++;
    Rst = 1'b1;
    tick(1);
    // Hold a word, then reset two bits into the next digit.
    word_ready = 1'b0;
    push_word(16'h4321);
    send_word(16'h4321, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    Rst = 1'b0;
    tick(2);
    outs = {digit, digit_valid, digit_err, word, word_err, word_valid, overrun};
    chk_cnt++;
    if (outs !== '0) $display("FAIL midframe_reset got=%h exp=0", outs);
    else pass_cnt++;
    flush_expect();
    Rst = 1'b1;
    tick(1);
    send_digit(4'd5, 0);
    tick(1);
    chk_cnt++;
    if (dig_q.size() != 0) $display("FAIL fresh_digit pending=%0d exp=0", dig_q.size());
    else pass_cnt++;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_word();
    int d0;
    int w0;
    logic [W-1:0] w;
    word_ready = 1'b1;
    d0 = dig_seen;
    w0 = wv_cycles;
    push_word(16'h1984);
    send_word(16'h1984, 0);
    chk_cnt++;
    if (word_valid !== 1'b1) $display("FAIL word_latency got=%b exp=1", word_valid);
    else pass_cnt++;
    tick(3);
    chk_cnt++;
    if (dig_seen - d0 != 4) $display("FAIL digit_pulses got=%0d exp=4", dig_seen - d0);
    else pass_cnt++;
    chk_cnt++;
    if (wv_cycles - w0 != 1) $display("FAIL word_valid_cycles got=%0d exp=1", wv_cycles - w0);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      push_word(w);
      send_word(w, $urandom_range(0, 2));
    end
    tick(3);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL random_words pending=%0d exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_digit_err();
    word_ready = 1'b1;
    push_word(16'h3C02);
    send_word(16'h3C02, 1);
    tick(3);
    chk_cnt++;
    if (exp_q.size() != 0 || dig_q.size() != 0)
      $display("FAIL err_word pending words=%0d digits=%0d exp=0", exp_q.size(), dig_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    word_ready = 1'b0;
    push_word(16'h1234);
    send_word(16'h1234, 0);
    send_word(16'h5678, 0);
    tick(1);
    chk_cnt++;
    if (word_valid !== 1'b1 || word !== 16'h1234)
      $display("FAIL held_word got valid=%b word=%h exp valid=1 word=1234", word_valid, word);
    else pass_cnt++;
    chk_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_set got=%b exp=1", overrun);
    else pass_cnt++;
    word_ready = 1'b1;
    tick(1);
    chk_cnt++;
    if (word_valid !== 1'b0) $display("FAIL accept_clears_valid got=%b exp=0", word_valid);
    else pass_cnt++;
    tick(2);
    chk_cnt++;
    if (overrun !== 1'b1 || exp_q.size() != 0)
      $display("FAIL overrun_sticky got=%b pending=%0d exp=1 pending=0", overrun, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    Rst = 1'b0;
    tick(1);
    Rst = 1'b1;
    flush_expect();
    tick(1);
    chk_cnt++;
    if (overrun !== 1'b0) $display("FAIL overrun_after_reset got=%b exp=0", overrun);
    else pass_cnt++;
    word_ready = 1'b0;
    push_word(16'h2468);
    send_word(16'h2468, 0);
    push_word(16'h1357);
    send_digit(4'h1, 0);
    send_digit(4'h3, 0);
    send_digit(4'h5, 0);
    d = 4'h7;
    dig_q.push_back({1'b0, d});
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    word_ready = 1'b1;
    send_bit(d[3]);
    chk_cnt++;
    if (word_valid !== 1'b1 || word !== 16'h1357)
      $display("FAIL same_edge_load got valid=%b word=%h exp valid=1 word=1357", word_valid, word);
    else pass_cnt++;
    tick(2);
    chk_cnt++;
    if (overrun !== 1'b0 || word_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL back_to_back got ovr=%b valid=%b pending=%0d exp 0 0 0", overrun, word_valid, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_clr();
    word_ready = 1'b1;
    send_digit(4'd9, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    // clr and bit_en together: the bit is lost.
    clr = 1'b1;
    bit_en = 1'b1;
    Z_in = 1'b1;
    tick(1);
    clr = 1'b0;
    bit_en = 1'b0;
    Z_in = 1'b0;
    push_word(16'h0007);
    send_word(16'h0007, 3);
    tick(3);
    chk_cnt++;
    if (exp_q.size() != 0 || dig_q.size() != 0)
      $display("FAIL clr_restart pending words=%0d digits=%0d exp=0", exp_q.size(), dig_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_digit_err();
    test_overrun();
    test_back_to_back();
    test_clr();
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
